// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between the L1 miss ports, the round-robin arbiter and physical memory.
// The arbiter takes the slave view; the caches/memory side (or a bench) takes the master view.
interface mem_arbiter_rr_if #(
    parameter int N_PORTS    = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0]            req_read;
    logic [N_PORTS-1:0]            req_write;
    logic [N_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [N_PORTS*LINE_WIDTH-1:0] req_wdata;
    logic [N_PORTS-1:0]            req_resp;
    logic [LINE_WIDTH-1:0]         req_rdata;

    logic                          pmem_resp;
    logic [LINE_WIDTH-1:0]         pmem_rdata;
    logic                          pmem_read;
    logic                          pmem_write;
    logic [ADDR_WIDTH-1:0]         pmem_address;
    logic [LINE_WIDTH-1:0]         pmem_wdata;

    logic                          grant_valid;
    logic [IDX_W-1:0]              grant_idx;

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, pmem_resp, pmem_rdata,
        output req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
               grant_valid, grant_idx
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata, pmem_resp, pmem_rdata,
        input  req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
               grant_valid, grant_idx
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter from L1 miss ports onto one line-wide memory port.
// Requests are latched at grant; a one-cycle DONE gap follows every completion.
module mem_arbiter_rr #(
    parameter int N_PORTS    = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_arbiter_rr_if.slave      bus
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [IDX_W:0]   PORTS_W   = (IDX_W+1)'(N_PORTS);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_PORTS-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]      grant_idx, grant_idx_nxt;
    logic                  cmd_write, cmd_write_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nxt;
    logic [LINE_WIDTH-1:0] lat_wdata, lat_wdata_nxt;

    logic [N_PORTS-1:0]    active;
    logic [2*N_PORTS-1:0]  active_dbl;
    logic [2*N_PORTS-1:0]  active_shift;
    logic [N_PORTS-1:0]    active_rot;
    logic                  win_found;
    logic [IDX_W-1:0]      win_offset;
    logic [IDX_W:0]        win_sum;
    logic [IDX_W-1:0]      win_idx;

    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_WIDTH-1:0] sel_wdata;
    logic                  busy;

    assign active       = bus.req_read | bus.req_write;
    assign active_dbl   = {active, active};
    assign active_shift = active_dbl >> rr_ptr;
    assign active_rot   = active_shift[N_PORTS-1:0];

    // Rotating the request vector by rr_ptr turns the fair scan into a
    // plain lowest-set-bit search; the offset is then mapped back to a port.
    always_comb begin
        win_found  = 1'b0;
        win_offset = '0;
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            if (active_rot[j]) begin
                win_found  = 1'b1;
                win_offset = IDX_W'(j);
            end
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, win_offset};
        if (win_sum >= PORTS_W) begin
            win_sum = win_sum - PORTS_W;
        end
        win_idx = win_sum[IDX_W-1:0];
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            if (win_idx == IDX_W'(j)) begin
                sel_write = bus.req_write[j];
                sel_addr  = bus.req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[j*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            cmd_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_idx <= grant_idx_nxt;
            cmd_write <= cmd_write_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
        end
    end

    // DONE never samples requests, giving the served cache a cycle to drop its request.
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_idx_nxt = grant_idx;
        cmd_write_nxt = cmd_write;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt     = BUSY;
                    grant_idx_nxt = win_idx;
                    cmd_write_nxt = sel_write;
                    lat_addr_nxt  = sel_addr;
                    lat_wdata_nxt = sel_wdata;
                end
            end
            BUSY: begin
                if (bus.pmem_resp) begin
                    state_nxt  = DONE;
                    rr_ptr_nxt = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy             = (state == BUSY);
    assign bus.pmem_read    = busy & ~cmd_write;
    assign bus.pmem_write   = busy & cmd_write;
    assign bus.pmem_address = busy ? lat_addr  : '0;
    assign bus.pmem_wdata   = busy ? lat_wdata : '0;
    assign bus.grant_valid  = busy;
    assign bus.grant_idx    = grant_idx;
    assign bus.req_rdata    = bus.pmem_rdata;

    always_comb begin
        bus.req_resp = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            bus.req_resp[j] = busy & bus.pmem_resp & (grant_idx == IDX_W'(j));
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: a 2-port and a 4-port instance, with expected
// grants queued by the stimulus and popped by per-instance monitors.
module tb_mem_arbiter_rr;
    localparam logic [31:0] RPAT = 32'hDEAD_BEEF;

    typedef struct {
        int           idx;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } exp_t;

    logic clk;
    logic rst_n;

    mem_arbiter_rr_if #(.N_PORTS(2)) bus2 ();
    mem_arbiter_rr_if #(.N_PORTS(4)) bus4 ();

    mem_arbiter_rr #(.N_PORTS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    mem_arbiter_rr #(.N_PORTS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q2[$];
    exp_t exp_q4[$];
    exp_t cur2, cur4;
    bit   prev_gv2 = 0, prev_gv4 = 0;
    bit   resp2_en = 1, resp4_en = 1;
    bit   manual2  = 0;
    int   lat2 = 3, lat4 = 2;
    int   cnt2 = 0, cnt4 = 0;
    bit   ok;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input int dut_sel, input int port, input bit rd, input bit wr,
                                 input logic [31:0] addr, input logic [255:0] wdata);
        if (dut_sel == 2) begin
            bus2.req_read[port]              = rd;
            bus2.req_write[port]             = wr;
            bus2.req_addr[port*32 +: 32]     = addr;
            bus2.req_wdata[port*256 +: 256]  = wdata;
        end else begin
            bus4.req_read[port]              = rd;
            bus4.req_write[port]             = wr;
            bus4.req_addr[port*32 +: 32]     = addr;
            bus4.req_wdata[port*256 +: 256]  = wdata;
        end
    endtask

    task automatic pushExp(input int dut_sel, input int idx, input bit wr,
                           input logic [31:0] addr, input logic [255:0] wdata);
        exp_t e;
        e.idx = idx; e.wr = wr; e.addr = addr; e.wdata = wdata;
        if (dut_sel == 2) exp_q2.push_back(e);
        else exp_q4.push_back(e);
    endtask

    // Returns at posedge+1 after the last response, i.e. inside the DONE cycle.
    task automatic waitResps(input int dut_sel, input int n, output bit got_all);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (dut_sel == 2 ? (bus2.req_resp != '0) : (bus4.req_resp != '0)) seen++;
        end
        checkOutput($sformatf("resp count dut%0d", dut_sel), seen, n);
        got_all = (seen == n);
        @(posedge clk); #1;
    endtask

    task automatic waitGrant2();
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus2.grant_valid && cyc < 50);
        checkOutput("grant seen dut2", bus2.grant_valid, 1);
    endtask

    // Memory models: respond lat cycles into each transaction with an address-derived line.
    initial begin
        bus2.pmem_resp = 0; bus2.pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!resp2_en) begin
                bus2.pmem_resp = manual2; cnt2 = 0;
            end else if (bus2.pmem_resp) begin
                bus2.pmem_resp = 0; cnt2 = 0; bus2.pmem_rdata = {8{$urandom}};
            end else if (bus2.pmem_read || bus2.pmem_write) begin
                cnt2++;
                if (cnt2 >= lat2) begin
                    bus2.pmem_resp  = 1;
                    bus2.pmem_rdata = {8{bus2.pmem_address ^ RPAT}};
                end
            end else cnt2 = 0;
        end
    end

    initial begin
        bus4.pmem_resp = 0; bus4.pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!resp4_en) begin
                bus4.pmem_resp = 0; cnt4 = 0;
            end else if (bus4.pmem_resp) begin
                bus4.pmem_resp = 0; cnt4 = 0; bus4.pmem_rdata = {8{$urandom}};
            end else if (bus4.pmem_read || bus4.pmem_write) begin
                cnt4++;
                if (cnt4 >= lat4) begin
                    bus4.pmem_resp  = 1;
                    bus4.pmem_rdata = {8{bus4.pmem_address ^ RPAT}};
                end
            end else cnt4 = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus2.grant_valid && !prev_gv2) begin
                if (exp_q2.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL d2 unexpected grant: got idx %0d expected none", bus2.grant_idx);
                end else begin
                    cur2 = exp_q2.pop_front();
                    checkOutput("d2 grant_idx", bus2.grant_idx, cur2.idx);
                    checkOutput("d2 strobes", {bus2.pmem_write, bus2.pmem_read}, {cur2.wr, ~cur2.wr});
                    checkOutput("d2 address", bus2.pmem_address, cur2.addr);
                    if (cur2.wr) checkOutput("d2 wdata", bus2.pmem_wdata, cur2.wdata);
                end
            end else if (bus2.grant_valid) begin
                checkOutput("d2 address hold", bus2.pmem_address, cur2.addr);
                checkOutput("d2 strobe hold", {bus2.pmem_write, bus2.pmem_read}, {cur2.wr, ~cur2.wr});
            end
            if (bus2.req_resp != '0) begin
                checkOutput("d2 req_resp", bus2.req_resp, 256'(1) << cur2.idx);
                checkOutput("d2 req_rdata", bus2.req_rdata, {8{cur2.addr ^ RPAT}});
            end
        end
        prev_gv2 = (bus2.grant_valid === 1'b1);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus4.grant_valid && !prev_gv4) begin
                if (exp_q4.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL d4 unexpected grant: got idx %0d expected none", bus4.grant_idx);
                end else begin
                    cur4 = exp_q4.pop_front();
                    checkOutput("d4 grant_idx", bus4.grant_idx, cur4.idx);
                    checkOutput("d4 strobes", {bus4.pmem_write, bus4.pmem_read}, {cur4.wr, ~cur4.wr});
                    checkOutput("d4 address", bus4.pmem_address, cur4.addr);
                    if (cur4.wr) checkOutput("d4 wdata", bus4.pmem_wdata, cur4.wdata);
                end
            end
            if (bus4.req_resp != '0) begin
                checkOutput("d4 req_resp", bus4.req_resp, 256'(1) << cur4.idx);
                checkOutput("d4 req_rdata", bus4.req_rdata, {8{cur4.addr ^ RPAT}});
            end
        end
        prev_gv4 = (bus4.grant_valid === 1'b1);
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 0;
        bus2.req_read = '0; bus2.req_write = '0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus4.req_read = '0; bus4.req_write = '0; bus4.req_addr = '0; bus4.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        checkOutput("reset grant_valid", bus2.grant_valid, 0);
        checkOutput("reset grant_idx", bus2.grant_idx, 0);
        checkOutput("reset strobes", {bus2.pmem_write, bus2.pmem_read}, 0);
        checkOutput("reset address", bus2.pmem_address, 0);
        checkOutput("reset wdata", bus2.pmem_wdata, 0);
        checkOutput("reset req_resp", bus2.req_resp, 0);
        checkOutput("reset d4 outputs", {bus4.grant_valid, bus4.pmem_read, bus4.pmem_write}, 0);

        // Single read on port 1: one-cycle grant latency, then DONE, then IDLE.
        @(posedge clk); #1;
        pushExp(2, 1, 0, 32'h0000_1000, '0);
        applyStimulus(2, 1, 1, 0, 32'h0000_1000, '0);
        @(negedge clk);
        checkOutput("pre-grant pmem_read", bus2.pmem_read, 0);
        @(negedge clk);
        checkOutput("grant latency pmem_read", bus2.pmem_read, 1);
        checkOutput("grant latency address", bus2.pmem_address, 32'h0000_1000);
        waitResps(2, 1, ok);
        applyStimulus(2, 1, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("done outputs", {bus2.grant_valid, bus2.pmem_read, bus2.pmem_write, bus2.req_resp}, 0);
        @(negedge clk);
        checkOutput("idle after done", bus2.grant_valid, 0);

        // Both ports requesting continuously: alternating grants.
        @(posedge clk); #1;
        lat2 = 2;
        pushExp(2, 0, 0, 32'h0000_0100, '0);
        pushExp(2, 1, 1, 32'h0000_0200, {32{8'hA5}});
        pushExp(2, 0, 0, 32'h0000_0100, '0);
        pushExp(2, 1, 1, 32'h0000_0200, {32{8'hA5}});
        applyStimulus(2, 0, 1, 0, 32'h0000_0100, '0);
        applyStimulus(2, 1, 0, 1, 32'h0000_0200, {32{8'hA5}});
        waitResps(2, 4, ok);
        applyStimulus(2, 0, 0, 0, '0, '0);
        applyStimulus(2, 1, 0, 0, '0, '0);
        repeat (2) @(posedge clk);

        // Granted port changes address and drops its request mid-BUSY.
        #1 lat2 = 5;
        pushExp(2, 0, 0, 32'h0000_1000, '0);
        applyStimulus(2, 0, 1, 0, 32'h0000_1000, '0);
        waitGrant2();
        @(posedge clk); #1;
        applyStimulus(2, 0, 0, 0, 32'h0000_2000, '0);
        @(negedge clk);
        checkOutput("latched address", bus2.pmem_address, 32'h0000_1000);
        checkOutput("latched pmem_read", bus2.pmem_read, 1);
        waitResps(2, 1, ok);
        repeat (2) @(negedge clk);
        checkOutput("no regrant after drop", bus2.grant_valid, 0);

        // Read and write together on port 1: write wins.
        @(posedge clk); #1;
        lat2 = 2;
        pushExp(2, 1, 1, 32'h0000_3000, {32{8'h3C}});
        applyStimulus(2, 1, 1, 1, 32'h0000_3000, {32{8'h3C}});
        waitResps(2, 1, ok);
        applyStimulus(2, 1, 0, 0, '0, '0);
        repeat (2) @(negedge clk);
        checkOutput("grant_idx held idle", bus2.grant_idx, 1);
        checkOutput("grant_valid idle", bus2.grant_valid, 0);

        // Serve port 0 so rr_ptr=1, then reset in the middle of a port-1 transaction.
        @(posedge clk); #1;
        pushExp(2, 0, 0, 32'h0000_4000, '0);
        applyStimulus(2, 0, 1, 0, 32'h0000_4000, '0);
        waitResps(2, 1, ok);
        applyStimulus(2, 0, 0, 0, '0, '0);
        @(negedge clk);
        resp2_en = 0;
        @(posedge clk); #1;
        pushExp(2, 1, 0, 32'h0000_5000, '0);
        applyStimulus(2, 1, 1, 0, 32'h0000_5000, '0);
        waitGrant2();
        @(posedge clk); #1;
        rst_n = 0;
        applyStimulus(2, 1, 0, 0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        checkOutput("mid-busy reset outputs",
                    {bus2.grant_valid, bus2.pmem_read, bus2.pmem_write, bus2.req_resp}, 0);
        checkOutput("mid-busy reset address", bus2.pmem_address, 0);
        checkOutput("mid-busy reset grant_idx", bus2.grant_idx, 0);
        manual2 = 1;
        @(negedge clk);
        checkOutput("late pmem_resp ignored", {bus2.grant_valid, bus2.req_resp}, 0);
        manual2 = 0;
        @(negedge clk);
        checkOutput("idle after late resp", {bus2.grant_valid, bus2.pmem_read}, 0);
        resp2_en = 1;
        @(posedge clk); #1;
        pushExp(2, 0, 0, 32'h0000_6000, '0);
        pushExp(2, 1, 0, 32'h0000_7000, '0);
        applyStimulus(2, 0, 1, 0, 32'h0000_6000, '0);
        applyStimulus(2, 1, 1, 0, 32'h0000_7000, '0);
        waitResps(2, 2, ok);
        applyStimulus(2, 0, 0, 0, '0, '0);
        applyStimulus(2, 1, 0, 0, '0, '0);

        // Four ports: serve port 2 so rr_ptr=3, then ports 0 and 3 compete.
        @(posedge clk); #1;
        pushExp(4, 2, 0, 32'h0000_8000, '0);
        applyStimulus(4, 2, 1, 0, 32'h0000_8000, '0);
        waitResps(4, 1, ok);
        applyStimulus(4, 2, 0, 0, '0, '0);
        @(posedge clk); #1;
        pushExp(4, 3, 1, 32'h0000_A000, {32{8'h5A}});
        pushExp(4, 0, 0, 32'h0000_9000, '0);
        applyStimulus(4, 0, 1, 0, 32'h0000_9000, '0);
        applyStimulus(4, 3, 0, 1, 32'h0000_A000, {32{8'h5A}});
        waitResps(4, 2, ok);
        applyStimulus(4, 0, 0, 0, '0, '0);
        applyStimulus(4, 3, 0, 0, '0, '0);

        repeat (5) @(negedge clk);
        checkOutput("d2 scoreboard drained", exp_q2.size(), 0);
        checkOutput("d4 scoreboard drained", exp_q4.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-port round-robin arbiter between L1 cache miss ports (I-cache, D-cache, future prefetcher/victim buffer) and a single line-wide physical memory port.
- Next generation of the fixed two-port I/D arbiter.
- Adds configurable port count, fair round-robin rotation, request latching, a post-response turnaround cycle and grant observability outputs.

Parameters:
- N_PORTS, 2, number of requesting ports; legal range 1..16
- LINE_WIDTH, 256, data width in bits of each line transfer
- ADDR_WIDTH, 32, address width in bits
- IDX_W, $clog2(N_PORTS) (minimum 1), width of grant_idx; derived, not overridden

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- req_read  in  N_PORTS  per-port line read request
- req_write  in  N_PORTS  per-port line write request
- req_addr  in  N_PORTS*ADDR_WIDTH  per-port address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  N_PORTS*LINE_WIDTH  per-port write line, same packing scheme
- req_resp  out  N_PORTS  per-port completion pulse
- req_rdata  out  LINE_WIDTH  read line, shared by all ports
- pmem_resp  in  1  memory completion
- pmem_rdata  in  LINE_WIDTH  memory read line
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_WIDTH  memory address
- pmem_wdata  out  LINE_WIDTH  memory write line
- grant_valid  out  1  high while a transaction is in flight (BUSY state)
- grant_idx  out  IDX_W  index of the granted port; held until the next grant

Behaviour:
- State machine has three states: IDLE, BUSY, DONE.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - Latched cmd/addr/wdata are cleared to 0.
  - All outputs are 0: req_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, grant_valid.
  - Reset mid-BUSY abandons the transaction. A pmem_resp arriving after reset is ignored.
- IDLE:
  - Port i is "active" when req_read[i] | req_write[i].
  - Winner is the first active port scanning rr_ptr, rr_ptr+1, ... and wrapping modulo N_PORTS.
  - With no active port, stay in IDLE.
  - On a winner, latch grant_idx, address, wdata and cmd at the edge, then go to BUSY.
  - Cmd is write if req_write is set, else read; write wins if both are set.
- BUSY:
  - pmem_read/pmem_write are driven from the latched cmd, exactly one of them high.
  - pmem_address and pmem_wdata are driven from the latched values.
  - Changes on req_* during BUSY, including a drop of the granted request, have no effect.
  - req_resp[grant_idx] = pmem_resp combinationally; all other req_resp bits are 0.
- req_rdata = pmem_rdata at all times; it is valid to the requester in the cycle its req_resp is high.
- On pmem_resp in BUSY:
  - At the next edge go to DONE.
  - rr_ptr = (grant_idx+1) mod N_PORTS.
  - pmem_read and pmem_write drop at that edge.
- DONE lasts exactly one cycle:
  - pmem strobes, req_resp and grant_valid are all 0.
  - Requests are not sampled.
  - DONE always goes to IDLE.
  - This gives the served cache one cycle to deassert its request.
- Latency:
  - A request present in IDLE at edge t gives pmem strobe high in cycle t+1 (one-cycle grant latency).
  - Back-to-back grants are separated by at least one DONE cycle and one IDLE cycle.
- pmem_resp outside BUSY is ignored.
- Fairness: with all N ports continuously requesting, each port is granted exactly once every N transactions.
- N_PORTS=1 degenerates to a registered pass-through with the DONE gap; rr_ptr stays 0.
- grant_idx keeps its last value when idle; grant_valid alone qualifies it.

Test Plan:
- Reset, then a single read on port 1 with addr 0x0000_1000 and pmem_resp after 3 cycles:
  - pmem_read rises 1 cycle after the request and pmem_address=0x0000_1000.
  - req_resp=2'b10 for 1 cycle, with req_rdata equal to pmem_rdata in that cycle.
  - Then DONE, then IDLE.
- N_PORTS=2, both ports requesting continuously (port0 read, port1 write with wdata 256'hA5..A5):
  - Grant order is 0,1,0,1.
  - pmem_write is high only on port-1 grants, with pmem_wdata=256'hA5..A5.
- N_PORTS=4, ports 0 and 3 requesting after port 2 was last served (rr_ptr=3):
  - Port 3 is granted first, then port 0.
- Granted port changes req_addr to 0x2000 and drops req_read mid-BUSY:
  - pmem_address stays at the latched 0x1000 and pmem_read stays high until pmem_resp.
- Port asserts req_read and req_write together:
  - pmem_write=1 and pmem_read=0.
- rst_n=0 for 1 cycle mid-BUSY, then pmem_resp=1:
  - All outputs are 0 after the reset edge and no req_resp is issued.
  - The next grant goes to the lowest active index (rr_ptr=0).
